// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : muldiv_sequencer_if
// Brief   : Request/response bundle between the ALU control path and the
//           iterative multiply/divide sequencer.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUCtrl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic             DivByZero;

  modport master (
    output start, ALUCtrl, SrcA, SrcB,
    input  busy, done, Result, DivByZero
  );

  modport slave (
    input  start, ALUCtrl, SrcA, SrcB,
    output busy, done, Result, DivByZero
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : muldiv_sequencer
// Brief   : One-bit-per-cycle shift-add multiplier and restoring unsigned
//           divider; stalls the pipeline (busy) while iterating.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  muldiv_sequencer_if.slave  bus
);

  localparam int              CW     = $clog2(WIDTH) + 1;
  localparam logic [1:0]      S_IDLE = 2'd0;
  localparam logic [1:0]      S_MUL  = 2'd1;
  localparam logic [1:0]      S_DIV  = 2'd2;
  localparam logic [1:0]      S_DONE = 2'd3;
  localparam logic [3:0]      OP_MUL = 4'b0011;
  localparam logic [3:0]      OP_DIV = 4'b0001;
  localparam logic [CW-1:0]   LAST   = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // multiplicand, or dividend/quotient
  logic [WIDTH-1:0] b_q, b_d;       // multiplier, or divisor
  logic [WIDTH-1:0] acc_q, acc_d;   // product accumulator, or remainder
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             dbz_q, dbz_d;

  logic             w_req_mul, w_req_div, w_div_zero, w_last;
  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_rem_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_sub;
  logic [WIDTH-1:0] w_quot;

  assign w_req_mul   = bus.start && (bus.ALUCtrl == OP_MUL);
  assign w_req_div   = bus.start && (bus.ALUCtrl == OP_DIV);
  assign w_div_zero  = (bus.SrcB == '0);
  assign w_last      = (cnt_q == LAST);
  assign w_mul_acc   = b_q[0] ? (acc_q + a_q) : acc_q;
  assign w_rem_shift = {acc_q, a_q[WIDTH-1]};
  assign w_ge        = (w_rem_shift >= {1'b0, b_q});
  // The true difference is below the divisor, so WIDTH bits suffice.
  assign w_rem_sub   = w_rem_shift[WIDTH-1:0] - b_q;
  assign w_quot      = {a_q[WIDTH-2:0], w_ge};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_req_mul)                    state_d = S_MUL;
        else if (w_req_div && w_div_zero) state_d = S_DONE;
        else if (w_req_div)               state_d = S_DIV;
      end
      S_MUL:   if (w_last) state_d = S_DONE;
      S_DIV:   if (w_last) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.Result    = result_q;
    bus.DivByZero = dbz_q;
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (w_req_mul || w_req_div) begin
          a_d   = bus.SrcA;
          b_d   = bus.SrcB;
          acc_d = '0;
          cnt_d = '0;
          dbz_d = 1'b0;
          if (w_req_div && w_div_zero) begin
            result_d = '1;
            dbz_d    = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = w_mul_acc;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (w_last) result_d = w_mul_acc;
      end
      S_DIV: begin
        acc_d = w_ge ? w_rem_sub : w_rem_shift[WIDTH-1:0];
        a_d   = w_quot;
        cnt_d = cnt_q + 1'b1;
        if (w_last) result_d = w_quot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_muldiv_sequencer
// Brief   : Self-checking bench: directed cases plus random traffic compared
//           every cycle against a transaction-level reference model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus();
  muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int errors  = 0;

  // Reference model: an accepted request completes at a known cycle.
  bit         m_busy, m_done, m_dbz, pend_dbz;
  int         cyc, dc;
  logic [W-1:0] m_res, pend_res;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_dbz = 0; pend_dbz = 0;
      cyc = 0; dc = 0; m_res = '0; pend_res = '0;
    end else begin
      if (!m_busy && bus.start && (bus.ALUCtrl == 4'b0011 || bus.ALUCtrl == 4'b0001)) begin
        m_busy = 1;
        m_dbz  = 0;
        if (bus.ALUCtrl == 4'b0011) begin
          pend_res = bus.SrcA * bus.SrcB; pend_dbz = 0; dc = cyc + W + 1;
        end else if (bus.SrcB == '0) begin
          pend_res = '1; pend_dbz = 1; dc = cyc + 1;
        end else begin
          pend_res = bus.SrcA / bus.SrcB; pend_dbz = 0; dc = cyc + W + 1;
        end
      end
      cyc++;
      m_done = 0;
      if (m_busy && cyc == dc + 1) m_busy = 0;
      if (m_busy && cyc == dc) begin
        m_res = pend_res; m_dbz = pend_dbz; m_done = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_busy", W'(bus.busy), W'(m_busy));
      chk("model_done", W'(bus.done), W'(m_done));
      chk("model_dbz",  W'(bus.DivByZero), W'(m_dbz));
      if (!m_busy || m_done) chk("model_result", bus.Result, m_res);
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input bit exp_dbz,
                        input int exp_lat, input int inject);
    int n;
    @(negedge clk);
    bus.start = 1'b1; bus.ALUCtrl = op; bus.SrcA = a; bus.SrcB = b;
    @(negedge clk);
    bus.start = 1'b0; bus.ALUCtrl = 4'b0000;
    n = 1;
    while (!bus.done && n < 200) begin
      if (n == inject) begin
        bus.start = 1'b1; bus.ALUCtrl = 4'b0011; bus.SrcA = 32'd5; bus.SrcB = 32'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk("latency", W'(n), W'(exp_lat));
    chk("result", bus.Result, exp_res);
    chk("dbz", W'(bus.DivByZero), W'(exp_dbz));
    @(negedge clk);
    chk("done_once", W'(bus.done), '0);
    chk("busy_fall", W'(bus.busy), '0);
  endtask

  initial begin
    bus.start = 1'b0; bus.ALUCtrl = 4'b0000; bus.SrcA = '0; bus.SrcB = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(bus.busy), '0);
    chk("rst_done", W'(bus.done), '0);
    chk("rst_result", bus.Result, '0);
    chk("rst_dbz", W'(bus.DivByZero), '0);
    reset = 1'b0;

    run_op(4'b0011, 32'd7, 32'd6, 32'd42, 0, 33, -1);
    // First negedge after accept is cycle 1: busy must already be high.
    @(negedge clk);
    bus.start = 1'b1; bus.ALUCtrl = 4'b0011; bus.SrcA = 32'hFFFFFFFF; bus.SrcB = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_c1", W'(bus.busy), 32'd1);
    repeat (32) @(negedge clk);
    chk("ovf_done", W'(bus.done), 32'd1);
    chk("ovf_result", bus.Result, 32'hFFFFFFFE);
    run_op(4'b0011, 32'h80000000, 32'h80000000, 32'd0, 0, 33, -1);
    run_op(4'b0001, 32'd100, 32'd7, 32'd14, 0, 33, -1);
    run_op(4'b0001, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 0, 33, -1);
    run_op(4'b0001, 32'd55, 32'd0, 32'hFFFFFFFF, 1, 1, -1);
    run_op(4'b0011, 32'd3, 32'd3, 32'd9, 0, 33, -1);

    @(negedge clk);
    bus.start = 1'b1; bus.ALUCtrl = 4'b0010; bus.SrcA = 32'd8; bus.SrcB = 32'd8;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_busy", W'(bus.busy), '0);
    chk("ign_result", bus.Result, 32'd9);
    run_op(4'b0011, 32'd11, 32'd13, 32'd143, 0, 33, 5);

    // Asynchronous abort partway through a divide.
    @(negedge clk);
    bus.start = 1'b1; bus.ALUCtrl = 4'b0001; bus.SrcA = 32'd100; bus.SrcB = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", W'(bus.busy), '0);
    chk("arst_done", W'(bus.done), '0);
    chk("arst_result", bus.Result, '0);
    chk("arst_dbz", W'(bus.DivByZero), '0);
    @(negedge clk);
    reset = 1'b0;
    run_op(4'b0011, 32'd7, 32'd6, 32'd42, 0, 33, -1);

    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge clk);
      r = int'($urandom % 4);
      bus.start   = ($urandom % 4) == 0;
      bus.ALUCtrl = (r == 0) ? 4'b0011 : (r == 2) ? 4'(($urandom % 16)) : 4'b0001;
      bus.SrcA    = ($urandom % 2) ? $urandom : ($urandom % 256);
      bus.SrcB    = ($urandom % 6 == 0) ? 32'd0 : ($urandom % 2) ? $urandom : ($urandom % 16);
    end
    bus.start = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire
